// File: rtl/ryuki_datatypes.sv
// Shared trace datatypes: trace element layout, arbiter state and default queue depth.
package ryuki_datatypes;

   localparam int unsigned DEFAULT_QUEUE_DEPTH = 4;
   localparam int unsigned TIME_W  = 32;
   localparam int unsigned PC_W    = 32;
   localparam int unsigned INSTR_W = 32;

   typedef struct packed {
      logic [TIME_W-1:0] time_start;
      logic [PC_W-1:0]   pc;
   } if_data_t;

   typedef struct packed {
      if_data_t           if_data;
      logic [INSTR_W-1:0] instr;
   } trace_output;

   typedef enum logic {
      ARB_IDLE    = 1'b0,
      ARB_PRESENT = 1'b1
   } arb_state_e;

   // Which queue the presented element came from; also used as the tie pointer.
   typedef enum logic {
      SRC_ID = 1'b0,
      SRC_WB = 1'b1
   } arb_src_e;

endpackage

// File: rtl/trace_merge_arbiter_fifo.sv
// Per-source trace queue with occupancy count and saturating drop accounting.
module trace_fifo
   import ryuki_datatypes::*;
#(
   parameter int unsigned DEPTH          = DEFAULT_QUEUE_DEPTH,
   parameter int unsigned DROP_CNT_WIDTH = 16,
   localparam int unsigned PTR_W         = $clog2(DEPTH),
   localparam int unsigned CNT_W         = PTR_W + 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push_i,
   input  logic                      pop_i,
   input  trace_output               data_i,
   output trace_output               head_o,
   output trace_output               head_next_o,
   output logic                      full_o,
   output logic                      empty_o,
   output logic [CNT_W-1:0]          count_o,
   output logic                      overflow_o,
   output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);

   trace_output               mem_q [DEPTH];
   trace_output               mem_d [DEPTH];
   logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]          count_q, count_d;
   logic                      overflow_q, overflow_d;
   logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
   logic                      do_pop, do_push, do_drop;

   assign full_o      = (count_q == CNT_W'(DEPTH));
   assign empty_o     = (count_q == '0);
   assign count_o     = count_q;
   assign head_o      = mem_q[rd_ptr_q];
   assign head_next_o = mem_q[rd_ptr_q + PTR_W'(1)];
   assign overflow_o  = overflow_q;
   assign drop_cnt_o  = drop_cnt_q;

   // Push/pop bookkeeping; a full queue still accepts when it pops the same cycle.
   always_comb begin
      do_pop     = pop_i && !empty_o;
      do_push    = push_i && (!full_o || do_pop);
      do_drop    = push_i && full_o && !do_pop;
      mem_d      = mem_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      overflow_d = overflow_q || do_drop;
      drop_cnt_d = drop_cnt_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (do_drop && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   // Queue state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q      <= '{default: '0};
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         mem_q      <= mem_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

endmodule

// File: rtl/trace_merge_arbiter.sv
// Merges ID and WB trace streams in time_start order into one valid/ready output.
module trace_merge_arbiter
   import ryuki_datatypes::*;
#(
   parameter int unsigned QUEUE_DEPTH    = DEFAULT_QUEUE_DEPTH,
   parameter int unsigned DROP_CNT_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  trace_output               id_data_i,
   input  logic                      id_data_ready,
   input  trace_output               wb_data_i,
   input  logic                      wb_data_ready,
   output trace_output               trace_data_o,
   output logic                      trace_valid_o,
   input  logic                      trace_ready_i,
   output logic                      id_overflow_o,
   output logic                      wb_overflow_o,
   output logic [DROP_CNT_WIDTH-1:0] id_drop_cnt_o,
   output logic [DROP_CNT_WIDTH-1:0] wb_drop_cnt_o
);

   localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

   arb_state_e       state_q, state_d;
   arb_src_e         src_q, src_d, rr_q, rr_d;
   trace_output      data_q, data_d;
   logic             id_rdy_q, id_rdy_d, wb_rdy_q, wb_rdy_d;
   trace_output      id_head, id_head_next, wb_head, wb_head_next;
   logic             id_full, id_empty, wb_full, wb_empty;
   logic [CNT_W-1:0] id_count, wb_count;
   logic             id_push, wb_push, id_pop, wb_pop;
   logic             xfer, id_av, wb_av, any_av, pick_wb, tie, load;
   trace_output      id_el, wb_el;

   assign trace_data_o  = data_q;
   assign trace_valid_o = (state_q == ARB_PRESENT);

   trace_fifo #(.DEPTH(QUEUE_DEPTH), .DROP_CNT_WIDTH(DROP_CNT_WIDTH)) u_id_fifo (
      .clk(clk), .rst(rst), .push_i(id_push), .pop_i(id_pop), .data_i(id_data_i),
      .head_o(id_head), .head_next_o(id_head_next), .full_o(id_full), .empty_o(id_empty),
      .count_o(id_count), .overflow_o(id_overflow_o), .drop_cnt_o(id_drop_cnt_o)
   );

   trace_fifo #(.DEPTH(QUEUE_DEPTH), .DROP_CNT_WIDTH(DROP_CNT_WIDTH)) u_wb_fifo (
      .clk(clk), .rst(rst), .push_i(wb_push), .pop_i(wb_pop), .data_i(wb_data_i),
      .head_o(wb_head), .head_next_o(wb_head_next), .full_o(wb_full), .empty_o(wb_empty),
      .count_o(wb_count), .overflow_o(wb_overflow_o), .drop_cnt_o(wb_drop_cnt_o)
   );

   // Rising-edge capture of the level-held ready inputs.
   always_comb begin
      id_rdy_d = id_data_ready;
      wb_rdy_d = wb_data_ready;
      id_push  = id_data_ready && !id_rdy_q;
      wb_push  = wb_data_ready && !wb_rdy_q;
   end

   // Candidate heads as they will stand after this cycle's pop, then winner selection.
   always_comb begin
      xfer   = (state_q == ARB_PRESENT) && trace_ready_i;
      id_pop = xfer && (src_q == SRC_ID);
      wb_pop = xfer && (src_q == SRC_WB);
      id_av  = id_pop ? (id_count > CNT_W'(1)) : !id_empty;
      id_el  = id_pop ? id_head_next : id_head;
      wb_av  = wb_pop ? (wb_count > CNT_W'(1)) : !wb_empty;
      wb_el  = wb_pop ? wb_head_next : wb_head;
      any_av = id_av || wb_av;
      tie    = 1'b0;
      if (id_av && wb_av) begin
         if (id_el.if_data.time_start == wb_el.if_data.time_start) begin
            tie     = 1'b1;
            pick_wb = (rr_q == SRC_WB);
         end else begin
            pick_wb = (wb_el.if_data.time_start < id_el.if_data.time_start);
         end
      end else begin
         pick_wb = wb_av;
      end
   end

   // State register and datapath flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ARB_IDLE;
         src_q    <= SRC_ID;
         rr_q     <= SRC_ID;
         data_q   <= '0;
         id_rdy_q <= 1'b0;
         wb_rdy_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         rr_q     <= rr_d;
         data_q   <= data_d;
         id_rdy_q <= id_rdy_d;
         wb_rdy_q <= wb_rdy_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE:    if (any_av) state_d = ARB_PRESENT;
         ARB_PRESENT: if (xfer)   state_d = any_av ? ARB_PRESENT : ARB_IDLE;
         default:     state_d = ARB_IDLE;
      endcase
   end

   // Output logic: load the winner when idle or on a transfer; hold otherwise.
   always_comb begin
      data_d = data_q;
      src_d  = src_q;
      rr_d   = rr_q;
      load   = any_av && ((state_q == ARB_IDLE) || xfer);
      if (load) begin
         data_d = pick_wb ? wb_el : id_el;
         src_d  = pick_wb ? SRC_WB : SRC_ID;
         if (tie) rr_d = (rr_q == SRC_ID) ? SRC_WB : SRC_ID;
      end
   end

endmodule

// File: tb/tb_trace_merge_arbiter.sv
// Directed testbench for trace_merge_arbiter.
module tb_trace_merge_arbiter;
   import ryuki_datatypes::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   trace_output id_data_i = '0, wb_data_i = '0;
   logic        id_data_ready = 1'b0, wb_data_ready = 1'b0, trace_ready_i = 1'b0;
   trace_output trace_data_o;
   logic        trace_valid_o, id_overflow_o, wb_overflow_o;
   logic [1:0]  id_drop_cnt_o, wb_drop_cnt_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   trace_merge_arbiter #(.QUEUE_DEPTH(4), .DROP_CNT_WIDTH(2)) dut (
      .clk(clk), .rst(rst),
      .id_data_i(id_data_i), .id_data_ready(id_data_ready),
      .wb_data_i(wb_data_i), .wb_data_ready(wb_data_ready),
      .trace_data_o(trace_data_o), .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
      .id_overflow_o(id_overflow_o), .wb_overflow_o(wb_overflow_o),
      .id_drop_cnt_o(id_drop_cnt_o), .wb_drop_cnt_o(wb_drop_cnt_o)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic trace_output mk(input logic [31:0] ts, input logic [31:0] tag);
      trace_output t;
      t.if_data.time_start = ts;
      t.if_data.pc         = tag;
      t.instr              = ~tag;
      return t;
   endfunction

   task automatic id_edge(input trace_output d);
      id_data_i = d; id_data_ready = 1'b1; tick();
      id_data_ready = 1'b0; tick();
   endtask

   task automatic both_edge(input trace_output di, input trace_output dw);
      id_data_i = di; wb_data_i = dw; id_data_ready = 1'b1; wb_data_ready = 1'b1; tick();
      id_data_ready = 1'b0; wb_data_ready = 1'b0; tick();
   endtask

   // Wait (bounded) for a transfer, check its data, and step past it.
   task automatic get_next(input string tag, input trace_output exp);
      int n = 0;
      while (!(trace_valid_o && trace_ready_i) && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_timeout"}, 128'(n < 20), 128'(1));
      chk(tag, 128'(trace_data_o), 128'(exp));
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1; tick();
      rst = 1'b0; tick();
   endtask

   initial begin
      tick(2);
      rst = 1'b0;
      tick();
      // Reset state
      chk("rst_valid", 128'(trace_valid_o), 128'(0));
      chk("rst_data", 128'(trace_data_o), 128'(0));
      chk("rst_ovf", 128'({id_overflow_o, wb_overflow_o}), 128'(0));
      chk("rst_cnt", 128'({id_drop_cnt_o, wb_drop_cnt_o}), 128'(0));

      // Single ID element, two-cycle latency, then idle
      trace_ready_i = 1'b1;
      id_data_i = mk(10, 32'h100); id_data_ready = 1'b1;
      tick();
      chk("lat_cap_valid", 128'(trace_valid_o), 128'(0));
      id_data_ready = 1'b0;
      tick();
      chk("lat_valid", 128'(trace_valid_o), 128'(1));
      chk("lat_data", 128'(trace_data_o), 128'(mk(10, 32'h100)));
      tick();
      chk("lat_idle", 128'(trace_valid_o), 128'(0));

      // Smaller time_start wins
      both_edge(mk(20, 32'h200), mk(15, 32'h201));
      get_next("ord_wb", mk(15, 32'h201));
      get_next("ord_id", mk(20, 32'h200));
      tick();
      chk("ord_idle", 128'(trace_valid_o), 128'(0));

      // Overflow with sink stalled, then pop+push on a full queue
      trace_ready_i = 1'b0;
      for (int i = 1; i <= 5; i++) id_edge(mk(32'(i), 32'h300 + 32'(i)));
      chk("ovf_flag", 128'(id_overflow_o), 128'(1));
      chk("ovf_cnt", 128'(id_drop_cnt_o), 128'(1));
      chk("ovf_wb_flag", 128'(wb_overflow_o), 128'(0));
      chk("ovf_head", 128'(trace_data_o), 128'(mk(1, 32'h301)));
      id_data_i = mk(6, 32'h306); id_data_ready = 1'b1; trace_ready_i = 1'b1;
      tick();
      id_data_ready = 1'b0;
      chk("full_pop_cnt", 128'(id_drop_cnt_o), 128'(1));
      for (int i = 2; i <= 4; i++) get_next($sformatf("ovf_e%0d", i), mk(32'(i), 32'h300 + 32'(i)));
      get_next("ovf_e6", mk(6, 32'h306));
      chk("ovf_idle", 128'(trace_valid_o), 128'(0));

      // Equal time_start: round-robin starting with ID after reset
      do_reset();
      trace_ready_i = 1'b0;
      both_edge(mk(7, 32'h400), mk(7, 32'h401));
      both_edge(mk(7, 32'h402), mk(7, 32'h403));
      trace_ready_i = 1'b1;
      get_next("rr_id0", mk(7, 32'h400));
      get_next("rr_wb0", mk(7, 32'h401));
      get_next("rr_id1", mk(7, 32'h402));
      get_next("rr_wb1", mk(7, 32'h403));

      // Sink stall: data held, no loss or duplicate
      trace_ready_i = 1'b0;
      both_edge(mk(3, 32'h500), mk(9, 32'h501));
      chk("stall_valid", 128'(trace_valid_o), 128'(1));
      chk("stall_x", 128'(trace_data_o), 128'(mk(3, 32'h500)));
      tick();
      chk("stall_hold", 128'(trace_data_o), 128'(mk(3, 32'h500)));
      trace_ready_i = 1'b1; tick();
      trace_ready_i = 1'b0;
      chk("stall_y", 128'(trace_data_o), 128'(mk(9, 32'h501)));
      tick();
      chk("stall_y_hold", 128'(trace_data_o), 128'(mk(9, 32'h501)));
      chk("stall_y_valid", 128'(trace_valid_o), 128'(1));
      trace_ready_i = 1'b1; tick();
      chk("stall_done", 128'(trace_valid_o), 128'(0));

      // Reset mid-operation with queued elements and a saturated drop counter
      trace_ready_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         id_data_i = mk(100 + 32'(i), 32'h600 + 32'(i));
         wb_data_i = mk(200 + 32'(i), 32'h700 + 32'(i));
         id_data_ready = (i < 3); wb_data_ready = 1'b1; tick();
         id_data_ready = 1'b0; wb_data_ready = 1'b0; tick();
      end
      chk("pre_rst_valid", 128'(trace_valid_o), 128'(1));
      chk("pre_rst_data", 128'(trace_data_o), 128'(mk(100, 32'h600)));
      chk("sat_cnt", 128'(wb_drop_cnt_o), 128'(3));
      chk("sat_ovf", 128'({id_overflow_o, wb_overflow_o}), 128'(1));
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 128'(trace_valid_o), 128'(0));
      chk("arst_data", 128'(trace_data_o), 128'(0));
      chk("arst_cnt", 128'({id_drop_cnt_o, wb_drop_cnt_o}), 128'(0));
      chk("arst_ovf", 128'({id_overflow_o, wb_overflow_o}), 128'(0));
      tick();
      rst = 1'b0;
      trace_ready_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("post_rst_quiet", 128'(trace_valid_o), 128'(0));
      end

      // Ready held high through reset release is a new edge
      rst = 1'b1;
      id_data_i = mk(42, 32'h800); id_data_ready = 1'b1;
      tick();
      rst = 1'b0;
      get_next("held_ready", mk(42, 32'h800));
      id_data_ready = 1'b0;
      tick(2);
      chk("held_ready_once", 128'(trace_valid_o), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
